// File: rtl/composition_pkg.sv
// Shared types and default widths for the composition-by-for datapath.
package composition_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWaitBusy,
    StWaitDone
  } state_e;

endpackage

// File: rtl/for_ctrl_if.sv
// Request-side and callee-side handshake bundle of the iteration controller.
interface for_ctrl_if
  import composition_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) ();

  logic              ST;
  logic              RD;
  logic [DATA_W-1:0] RES;
  logic [CNT_W-1:0]  N;
  logic [DATA_W-1:0] X0;
  logic [DATA_W-1:0] C;

  logic              F_ST;
  logic              F_RD;
  logic [DATA_W-1:0] F_RES;
  logic [DATA_W-1:0] F_IN1;
  logic [DATA_W-1:0] F_IN2;
  logic [DATA_W-1:0] F_IN3;

  // The controller side.
  modport slave (
    input  ST, N, X0, C, F_RD, F_RES,
    output RD, RES, F_ST, F_IN1, F_IN2, F_IN3
  );

  // The environment: requester plus function unit.
  modport master (
    output ST, N, X0, C, F_RD, F_RES,
    input  RD, RES, F_ST, F_IN1, F_IN2, F_IN3
  );

endinterface

// File: rtl/for_ctrl.sv
// Iteration controller: runs a start/ready function unit N times, feeding each
// result back as the next IN2 operand, and returns the final value.
module for_ctrl
  import composition_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  for_ctrl_if.slave  bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  k_q, k_d, n_q, n_d;
  logic [CNT_W-1:0]  k_inc;
  logic [DATA_W-1:0] acc_q, acc_d, c_q, c_d, res_q, res_d;
  logic              rd_q, rd_d;
  logic              accept, f_done, last_iter, f_st;

  assign accept    = (state_q == StIdle) && rd_q && bus.ST;
  assign f_done    = (state_q == StWaitDone) && bus.F_RD;
  assign k_inc     = k_q + CNT_W'(1);
  assign last_iter = (k_inc == n_q);

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (accept && (bus.N != '0)) state_d = StLaunch;
      StLaunch:   if (bus.F_RD) state_d = StWaitBusy;
      // Callee may drop RD a cycle or more after accepting the start.
      StWaitBusy: if (!bus.F_RD) state_d = StWaitDone;
      StWaitDone: if (bus.F_RD) state_d = last_iter ? StIdle : StLaunch;
      default:    state_d = StIdle;
    endcase
  end

  // Output logic: the only combinational path is F_RD -> F_ST.
  always_comb begin
    f_st = (state_q == StLaunch) && bus.F_RD;
  end

  // Datapath next-state.
  always_comb begin
    k_d   = k_q;
    n_d   = n_q;
    acc_d = acc_q;
    c_d   = c_q;
    res_d = res_q;
    rd_d  = rd_q;
    if (accept) begin
      n_d   = bus.N;
      c_d   = bus.C;
      acc_d = bus.X0;
      k_d   = '0;
      if (bus.N == '0) begin
        res_d = bus.X0;
      end else begin
        rd_d = 1'b0;
      end
    end else if (f_done) begin
      acc_d = bus.F_RES;
      k_d   = k_inc;
      if (last_iter) begin
        res_d = bus.F_RES;
        rd_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      k_q   <= '0;
      n_q   <= '0;
      acc_q <= '0;
      c_q   <= '0;
      res_q <= '0;
      rd_q  <= 1'b1;
    end else begin
      k_q   <= k_d;
      n_q   <= n_d;
      acc_q <= acc_d;
      c_q   <= c_d;
      res_q <= res_d;
      rd_q  <= rd_d;
    end
  end

  // Operands come straight from registers that only change on accept/done edges.
  assign bus.F_ST  = f_st;
  assign bus.F_IN1 = DATA_W'(k_q);
  assign bus.F_IN2 = acc_q;
  assign bus.F_IN3 = c_q;
  assign bus.RD    = rd_q;
  assign bus.RES   = res_q;

endmodule

// File: tb/tb_for_ctrl.sv
// Bench for for_ctrl with a behavioural decrement-by-one callee.
module tb_for_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  for_ctrl_if #(.DATA_W(16), .CNT_W(8)) bus ();

  for_ctrl #(.DATA_W(16), .CNT_W(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Callee: accepts a start, stays busy, returns IN2-1.
  logic        cal_rd;
  logic [15:0] cal_res;
  int          cal_cnt;
  logic        hold;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cal_rd  <= 1'b1;
      cal_cnt <= 0;
      cal_res <= '0;
    end else if (cal_rd && bus.F_ST) begin
      cal_rd  <= 1'b0;
      cal_cnt <= 4;
      cal_res <= bus.F_IN2 - 16'd1;
    end else if (!cal_rd) begin
      if (cal_cnt == 1) cal_rd <= 1'b1;
      cal_cnt <= cal_cnt - 1;
    end
  end

  assign bus.F_RD  = cal_rd & ~hold;
  assign bus.F_RES = cal_res;

  // Operand monitor: expected k / acc / C at each launch.
  logic [15:0] mon_k, mon_acc, mon_c;
  int          fst_cnt = 0;

  always @(negedge CLK) begin
    if (RST && bus.F_ST) begin
      fst_cnt++;
      chk("f_in1", bus.F_IN1, mon_k);
      chk("f_in2", bus.F_IN2, mon_acc);
      mon_k   = mon_k + 16'd1;
      mon_acc = mon_acc - 16'd1;
    end
    if (RST && !bus.RD) chk("f_in3", bus.F_IN3, mon_c);
  end

  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0]  n;
    logic [15:0] x0;
    logic [15:0] c;
    int          hold;
    bit          spam;
    logic [15:0] exp_res;
  } vec_t;

  vec_t vecs[6];

  task automatic run(input vec_t v);
    int          cyc;
    int          f0;
    bit          done;
    logic [15:0] e;
    @(negedge CLK);
    bus.ST  = 1'b1;
    bus.N   = v.n;
    bus.X0  = v.x0;
    bus.C   = v.c;
    hold    = (v.hold > 0);
    mon_k   = 16'd0;
    mon_acc = v.x0;
    mon_c   = v.c;
    f0      = fst_cnt;
    exp_q.push_back(v.exp_res);
    @(posedge CLK);
    #1;
    bus.ST = 1'b0;
    if (v.n == 8'd0) begin
      e = exp_q.pop_front();
      chk("n0_rd", bus.RD, 1);
      chk("n0_res", bus.RES, e);
      repeat (3) begin
        @(negedge CLK);
        chk("n0_rd_hold", bus.RD, 1);
      end
      chk("n0_no_fst", fst_cnt, f0);
      return;
    end
    chk("rd_drop", bus.RD, 0);
    cyc = 0;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge CLK);
      chk("fst_withheld", bus.F_ST, 0);
      if (i > 0) cyc++;
    end
    hold = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge CLK);
      cyc++;
      #1;
      if (bus.RD) done = 1'b1;
      else if (v.spam) begin
        bus.ST = ~bus.ST;
        bus.N  = 8'd5;
        bus.X0 = 16'd77;
      end
    end
    bus.ST = 1'b0;
    e = exp_q.pop_front();
    chk("rd_rise", bus.RD, 1);
    chk("res", bus.RES, e);
    chk("cycles", cyc, 6 * int'(v.n) + ((v.hold > 0) ? v.hold - 1 : 0));
    chk("launches", fst_cnt - f0, int'(v.n));
    repeat (3) begin
      @(negedge CLK);
      chk("idle_rd", bus.RD, 1);
      chk("idle_res", bus.RES, e);
    end
  endtask

  initial begin
    bus.ST = 1'b0;
    bus.N  = '0;
    bus.X0 = '0;
    bus.C  = '0;
    hold   = 1'b0;
    mon_k = '0; mon_acc = '0; mon_c = '0;

    vecs[0] = '{n: 8'd3, x0: 16'd100,  c: 16'd7, hold: 0, spam: 1'b0, exp_res: 16'd97};
    vecs[1] = '{n: 8'd0, x0: 16'd5,    c: 16'd1, hold: 0, spam: 1'b0, exp_res: 16'd5};
    vecs[2] = '{n: 8'd2, x0: 16'd10,   c: 16'd2, hold: 0, spam: 1'b1, exp_res: 16'd8};
    vecs[3] = '{n: 8'd2, x0: 16'd50,   c: 16'd3, hold: 3, spam: 1'b0, exp_res: 16'd48};
    vecs[4] = '{n: 8'd1, x0: 16'd0,    c: 16'd4, hold: 0, spam: 1'b0, exp_res: 16'hFFFF};
    vecs[5] = '{n: 8'd5, x0: 16'd1000, c: 16'd9, hold: 0, spam: 1'b0, exp_res: 16'd995};

    #12;
    chk("rst_rd", bus.RD, 1);
    chk("rst_res", bus.RES, 0);
    chk("rst_fst", bus.F_ST, 0);
    chk("rst_in1", bus.F_IN1, 0);
    chk("rst_in2", bus.F_IN2, 0);
    chk("rst_in3", bus.F_IN3, 0);
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 6; i++) run(vecs[i]);

    // Abort mid-run: reset lands in the second WAIT_DONE of an N=4 run.
    @(negedge CLK);
    bus.ST = 1'b1; bus.N = 8'd4; bus.X0 = 16'd20; bus.C = 16'd6;
    mon_k = 16'd0; mon_acc = 16'd20; mon_c = 16'd6;
    @(posedge CLK);
    #1;
    bus.ST = 1'b0;
    repeat (9) @(posedge CLK);
    #2;
    chk("pre_abort_rd", bus.RD, 0);
    RST = 1'b0;
    #1;
    chk("abort_rd", bus.RD, 1);
    chk("abort_res", bus.RES, 0);
    chk("abort_fst", bus.F_ST, 0);
    chk("abort_in1", bus.F_IN1, 0);
    chk("abort_in2", bus.F_IN2, 0);
    chk("abort_in3", bus.F_IN3, 0);
    @(negedge CLK);
    RST = 1'b1;
    run('{n: 8'd1, x0: 16'd1, c: 16'd0, hold: 0, spam: 1'b0, exp_res: 16'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
